multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multicycle control FSM for the filter-GPU ARM-subset core. It steps each instruction through fetch, decode, execute, memory and writeback states, drawing on one shared ALU and one shared memory port. It holds the NZCV flags register and evaluates condition codes. It gates every architectural write enable, and it sits between the instruction register and the datapath mux and enable inputs.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Instr  in  32  current instruction register contents: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, sampled in EXEC states
- MemReady  in  1  memory-port handshake (used only with SEQ_MEM_WAIT_EN)
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  architectural write enables
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result
- ALUSrcA  out  2  00=Rn, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=Rm, 01=Imm, 10=const 4
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALU result
- ALUOp  out  2  00=ADD, 01=SUB, 10=decode from Funct[4:1]
- Flags  out  4  registered NZCV
- State  out  4  current state encoding, for debug
- Illegal  out  1  one-cycle pulse in DECODE when Op=11

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (computes PC+8). Cond is evaluated against the registered Flags and the result is latched as CondEx.
  - CondEx=0 or Op=11: next state is FETCH.
  - Op=01: next state is MEMADR.
  - Op=00 with Funct[5]=0: next state is EXECR.
  - Op=00 with Funct[5]=1: next state is EXECI.
  - Op=10: next state is BRANCH.
- Condition codes follow the standard ARM table 0000 EQ through 1110 AL. Cond=1111 evaluates false.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=00. Next state is MEMRD if Funct[0]=1 (load), otherwise MEMWR.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next state is FETCH.
- EXECR / EXECI: ALUSrcB=00 / 01, ALUOp=10. Flags are written from ALUFlags when Funct[0]=1. Next state is ALUWB.
- ALUWB: ResultSrc=00. RegWrite=1 unless Funct[4:1]=1010 (CMP). Next state is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1. Next state is FETCH.
- RegWrite, MemWrite and flag writes require CondEx=1. PCWrite in FETCH does not.
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore-decoded from the registered state. The only additional gating is CondEx, which is registered.
- Instruction latency in cycles (no wait states):
  - Data-processing: 4.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Failed condition, or Op=11: 2.
- Flags update on the rising edge that leaves EXECR or EXECI. They are visible to the next instruction's DECODE.
- RST assertion:
  - State becomes FETCH, Flags becomes 0000, CondEx becomes 0, all immediately.
  - PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0 while RST=1.
  - Reset in mid-instruction abandons that instruction with no further writes.
- First fetch happens on the first rising edge after RST deasserts.

## Configuration
- SEQ_MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs while MemReady=0.
  - IRWrite and PCWrite in FETCH, and MemWrite in MEMWR, assert only in the cycle where MemReady=1.
  - The state advances on that same edge.
- SEQ_MEM_WAIT_EN undefined: MemReady is ignored and every memory access takes one cycle.

## Test plan
- Reset then release with Instr=0xE0812003 (ADD R2,R1,R3): states 0,1,6,8,0. RegWrite=1 only in ALUWB. PCWrite=1 only in FETCH.
- Instr=0xE5912004 (LDR): states 0,1,2,3,4,0. AdrSrc=1 in MEMRD. ResultSrc=01 and RegWrite=1 in MEMWB.
- SUBS with ALUFlags=0100, then Instr=0x00812003 (ADDEQ): Flags=0100, so ALUWB RegWrite=1. Repeat with Flags=0000: DECODE goes to FETCH and no RegWrite.
- CMP (Funct=010101) with ALUFlags=1000: Flags=1000 and RegWrite=0 in ALUWB. Instr Op=11: Illegal pulses once and the next state is FETCH.
- With SEQ_MEM_WAIT_EN, hold MemReady=0 for 3 cycles in MEMWR: State stays 5, MemWrite=0, then exactly one MemWrite=1 cycle.
- Assert RST during MEMRD: State goes to 0 and Flags to 0 asynchronously, with no RegWrite afterward.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the ARM-subset core: fetch/decode/execute/memory/writeback
// sequencing, NZCV flags, condition evaluation. Optional memory wait states: SEQ_MEM_WAIT_EN.
module multicycle_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Flags,
  output logic [3:0]  State,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic       condex_q, condex_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok;
  logic       mem_ready;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];

  logic unused_instr;
  assign unused_instr = ^{Instr[19:0]};

`ifdef SEQ_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign mem_ready = 1'b1;
`endif

  // Flags bit order is {N,Z,C,V}.
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flags_q[2];
      4'b0001: cond_ok = ~flags_q[2];
      4'b0010: cond_ok = flags_q[1];
      4'b0011: cond_ok = ~flags_q[1];
      4'b0100: cond_ok = flags_q[3];
      4'b0101: cond_ok = ~flags_q[3];
      4'b0110: cond_ok = flags_q[0];
      4'b0111: cond_ok = ~flags_q[0];
      4'b1000: cond_ok = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ok = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    condex_d = condex_q;
    flags_d  = flags_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        condex_d = cond_ok;
        if (!cond_ok || op == 2'b11) state_d = S_FETCH;
        else if (op == 2'b01)        state_d = S_MEMADR;
        else if (op == 2'b10)        state_d = S_BRANCH;
        else if (funct[5])           state_d = S_EXECI;
        else                         state_d = S_EXECR;
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI: begin
        if (funct[0] && condex_q) flags_d = ALUFlags;
        state_d = S_ALUWB;
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_FETCH;
      condex_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      condex_q <= condex_d;
      flags_q  <= flags_d;
    end
  end

  // Moore decode; write enables are additionally killed while reset is held.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        Illegal = (op == 2'b11);
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex_q;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q & mem_ready;
      end
      S_EXECR: ALUOp = 2'b10;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:  RegWrite = condex_q & (funct[4:1] != 4'b1010);
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
    if (RST) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign Flags = flags_q;
  assign State = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: state traces, control decode, flags, reset.
module tb_multicycle_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [3:0]  Flags, State;

  int checks = 0;
  int errors = 0;

  // Per-cycle observations captured by the driver task.
  logic [3:0] obs_state [16];
  logic [5:0] obs_ctl   [16]; // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,Illegal}
  logic [7:0] obs_mux   [16]; // {ALUSrcA,ALUSrcB,ResultSrc,ALUOp}
  logic [3:0] obs_flags [16];

  multicycle_sequencer dut (
    .CLK(CLK), .RST(RST), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .Flags(Flags), .State(State), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int n);
    Instr = ins;
    for (int i = 0; i < n; i++) begin
      obs_state[i] = State;
      obs_ctl[i]   = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal};
      obs_mux[i]   = {ALUSrcA, ALUSrcB, ResultSrc, ALUOp};
      step();
      obs_flags[i] = Flags;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; MemReady = 1'b1;
    repeat (2) step();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", State); end
    checks++; if (Flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b exp 0000", Flags); end
    checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite, Illegal} !== 5'b0) begin
      errors++; $display("FAIL reset_we got %b exp 00000", {PCWrite, IRWrite, RegWrite, MemWrite, Illegal}); end
    RST = 1'b0;
    #1;
    checks++; if ({PCWrite, IRWrite} !== 2'b11) begin
      errors++; $display("FAIL release_fetch got %b exp 11", {PCWrite, IRWrite}); end
  endtask

  task automatic test_add();
    logic [3:0] es [4];
    logic [5:0] ec [4];
    logic [7:0] em [4];
    es = '{4'd0, 4'd1, 4'd6, 4'd8};
    ec = '{6'b110000, 6'b000000, 6'b000000, 6'b001000};
    em = '{8'b01101000, 8'b01100000, 8'b00000010, 8'b00000000};
    run_instr(32'hE0812003, 4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_state[i] !== es[i]) begin errors++; $display("FAIL add_state[%0d] got %0d exp %0d", i, obs_state[i], es[i]); end
      checks++; if (obs_ctl[i] !== ec[i]) begin errors++; $display("FAIL add_ctl[%0d] got %b exp %b", i, obs_ctl[i], ec[i]); end
      checks++; if (obs_mux[i] !== em[i]) begin errors++; $display("FAIL add_mux[%0d] got %b exp %b", i, obs_mux[i], em[i]); end
    end
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL add_end got %0d exp 0", State); end
  endtask

  task automatic test_addi();
    logic [3:0] es [4];
    es = '{4'd0, 4'd1, 4'd7, 4'd8};
    run_instr(32'hE2812003, 4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_state[i] !== es[i]) begin errors++; $display("FAIL addi_state[%0d] got %0d exp %0d", i, obs_state[i], es[i]); end
    end
    checks++; if (obs_mux[2] !== 8'b00010010) begin errors++; $display("FAIL addi_exec_mux got %b exp 00010010", obs_mux[2]); end
    checks++; if (obs_ctl[3] !== 6'b001000) begin errors++; $display("FAIL addi_wb_ctl got %b exp 001000", obs_ctl[3]); end
  endtask

  task automatic test_ldr();
    logic [3:0] es [5];
    logic [5:0] ec [5];
    logic [7:0] em [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ec = '{6'b110000, 6'b000000, 6'b000000, 6'b000010, 6'b001000};
    em = '{8'b01101000, 8'b01100000, 8'b00010000, 8'b00000000, 8'b00000100};
    run_instr(32'hE5912004, 5);
    for (int i = 0; i < 5; i++) begin
      checks++; if (obs_state[i] !== es[i]) begin errors++; $display("FAIL ldr_state[%0d] got %0d exp %0d", i, obs_state[i], es[i]); end
      checks++; if (obs_ctl[i] !== ec[i]) begin errors++; $display("FAIL ldr_ctl[%0d] got %b exp %b", i, obs_ctl[i], ec[i]); end
      checks++; if (obs_mux[i] !== em[i]) begin errors++; $display("FAIL ldr_mux[%0d] got %b exp %b", i, obs_mux[i], em[i]); end
    end
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL ldr_end got %0d exp 0", State); end
  endtask

  task automatic test_str();
    logic [3:0] es [4];
    logic [5:0] ec [4];
    es = '{4'd0, 4'd1, 4'd2, 4'd5};
    ec = '{6'b110000, 6'b000000, 6'b000000, 6'b000110};
    run_instr(32'hE5812004, 4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_state[i] !== es[i]) begin errors++; $display("FAIL str_state[%0d] got %0d exp %0d", i, obs_state[i], es[i]); end
      checks++; if (obs_ctl[i] !== ec[i]) begin errors++; $display("FAIL str_ctl[%0d] got %b exp %b", i, obs_ctl[i], ec[i]); end
    end
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL str_end got %0d exp 0", State); end
  endtask

  task automatic test_branch();
    logic [3:0] es [3];
    logic [5:0] ec [3];
    es = '{4'd0, 4'd1, 4'd9};
    ec = '{6'b110000, 6'b000000, 6'b100000};
    run_instr(32'hEA000000, 3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs_state[i] !== es[i]) begin errors++; $display("FAIL b_state[%0d] got %0d exp %0d", i, obs_state[i], es[i]); end
      checks++; if (obs_ctl[i] !== ec[i]) begin errors++; $display("FAIL b_ctl[%0d] got %b exp %b", i, obs_ctl[i], ec[i]); end
    end
    checks++; if (obs_mux[2] !== 8'b10011000) begin errors++; $display("FAIL b_mux got %b exp 10011000", obs_mux[2]); end
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL b_end got %0d exp 0", State); end
  endtask

  task automatic test_cond();
    ALUFlags = 4'b0100;
    run_instr(32'hE0512003, 4);
    checks++; if (obs_flags[3] !== 4'b0100) begin errors++; $display("FAIL subs_z_flags got %b exp 0100", obs_flags[3]); end
    ALUFlags = 4'b0000;
    run_instr(32'h00812003, 4);
    checks++; if (obs_state[2] !== 4'd6) begin errors++; $display("FAIL addeq_taken_state got %0d exp 6", obs_state[2]); end
    checks++; if (obs_ctl[3] !== 6'b001000) begin errors++; $display("FAIL addeq_taken_rw got %b exp 001000", obs_ctl[3]); end
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL addeq_noS_flags got %b exp 0100", Flags); end
    run_instr(32'hE0512003, 4);
    checks++; if (obs_flags[3] !== 4'b0000) begin errors++; $display("FAIL subs_nz_flags got %b exp 0000", obs_flags[3]); end
    run_instr(32'h00812003, 2);
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL addeq_skip_state got %0d exp 0", State); end
    checks++; if (obs_ctl[1][3] !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL addeq_skip_rw got %b%b exp 00", obs_ctl[1][3], RegWrite); end
  endtask

  task automatic test_cmp_illegal();
    ALUFlags = 4'b1000;
    run_instr(32'hE1512003, 4);
    checks++; if (obs_state[3] !== 4'd8) begin errors++; $display("FAIL cmp_state got %0d exp 8", obs_state[3]); end
    checks++; if (obs_ctl[3] !== 6'b000000) begin errors++; $display("FAIL cmp_ctl got %b exp 000000", obs_ctl[3]); end
    checks++; if (obs_flags[3] !== 4'b1000) begin errors++; $display("FAIL cmp_flags got %b exp 1000", obs_flags[3]); end
    ALUFlags = 4'b0000;
    run_instr(32'hEC000000, 2);
    checks++; if (obs_ctl[0][0] !== 1'b0 || obs_ctl[1] !== 6'b000001) begin
      errors++; $display("FAIL illegal_pulse got %b,%b exp 0,000001", obs_ctl[0][0], obs_ctl[1]); end
    checks++; if (State !== 4'd0 || Illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_next got %0d/%b exp 0/0", State, Illegal); end
    // Cond=1111 never executes, even an S-type op that would rewrite flags.
    ALUFlags = 4'b0110;
    run_instr(32'hF0512003, 2);
    checks++; if (State !== 4'd0 || Flags !== 4'b1000) begin
      errors++; $display("FAIL nv_skip got %0d/%b exp 0/1000", State, Flags); end
    // GT with N=1,V=0 is false; LT is true.
    run_instr(32'hC0812003, 2);
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL gt_skip got %0d exp 0", State); end
    run_instr(32'hB0812003, 4);
    checks++; if (obs_state[2] !== 4'd6 || obs_ctl[3] !== 6'b001000) begin
      errors++; $display("FAIL lt_taken got %0d/%b exp 6/001000", obs_state[2], obs_ctl[3]); end
  endtask

  task automatic test_reset_mid();
    Instr = 32'hE5912004;
    repeat (3) step();
    checks++; if (State !== 4'd3) begin errors++; $display("FAIL mid_pre_state got %0d exp 3", State); end
    RST = 1'b1;
    #1;
    checks++; if (State !== 4'd0 || Flags !== 4'h0) begin
      errors++; $display("FAIL mid_async got %0d/%b exp 0/0000", State, Flags); end
    checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0) begin
      errors++; $display("FAIL mid_we got %b exp 0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
    step();
    RST = 1'b0;
    Instr = 32'hF0000000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
        errors++; $display("FAIL mid_after[%0d] got %b%b exp 00", i, RegWrite, MemWrite); end
      step();
    end
    checks++; if (State !== 4'd1) begin errors++; $display("FAIL mid_restart got %0d exp 1", State); end
    step();
  endtask

  task automatic test_mem_wait();
`ifdef SEQ_MEM_WAIT_EN
    Instr = 32'hE5812004;
    MemReady = 1'b0;
    #1;
    checks++; if ({PCWrite, IRWrite} !== 2'b00) begin errors++; $display("FAIL wait_fetch_we got %b exp 00", {PCWrite, IRWrite}); end
    step();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL wait_fetch_hold got %0d exp 0", State); end
    MemReady = 1'b1;
    #1;
    checks++; if ({PCWrite, IRWrite} !== 2'b11) begin errors++; $display("FAIL wait_fetch_go got %b exp 11", {PCWrite, IRWrite}); end
    repeat (3) step();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (State !== 4'd5 || MemWrite !== 1'b0) begin
        errors++; $display("FAIL wait_memwr[%0d] got %0d/%b exp 5/0", i, State, MemWrite); end
      step();
    end
    MemReady = 1'b1;
    #1;
    checks++; if (State !== 4'd5 || MemWrite !== 1'b1) begin
      errors++; $display("FAIL wait_memwr_go got %0d/%b exp 5/1", State, MemWrite); end
    step();
    checks++; if (State !== 4'd0 || MemWrite !== 1'b0) begin
      errors++; $display("FAIL wait_memwr_end got %0d/%b exp 0/0", State, MemWrite); end
`else
    MemReady = 1'b0;
    run_instr(32'hE5812004, 4);
    checks++; if (obs_state[3] !== 4'd5 || obs_ctl[3] !== 6'b000110 || State !== 4'd0) begin
      errors++; $display("FAIL nowait_str got %0d/%b/%0d exp 5/000110/0", obs_state[3], obs_ctl[3], State); end
    MemReady = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_ldr();
    test_str();
    test_branch();
    test_cond();
    test_cmp_illegal();
    test_reset_mid();
    test_mem_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
